vga_fetch: RTL and testbench
============================

# vga_fetch

Wishbone read master that streams the RGB565 framebuffer from SDRAM into the write side of the display's async pixel FIFO. It sits in the system clock domain, directly upstream of the VGA timing and output stage. It walks the frame linearly and buffers each acknowledged word in a 2-entry output buffer. It runs at most one frame ahead of the display, re-arming on each frame-sync pulse.

## Interface
Parameters:
- HDISP, 640, active pixels per line
- VDISP, 480, active lines per frame
- BASE_ADDR, 32'h0, byte address of framebuffer 0

Ports:
- CLK  in  1  system/Wishbone clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- frame_sync  in  1  single-cycle pulse, already synchronised to CLK, once per display frame
- buf_swap  in  1  single-cycle pulse requesting a framebuffer swap (used only with DBLBUF, see Configuration)
- wshb_adr  out  32  byte address
- wshb_cyc, wshb_stb  out  1  bus cycle/strobe
- wshb_we  out  1  constant 0
- wshb_sel  out  2  constant 2'b11
- wshb_cti  out  3  constant 0 (classic)
- wshb_bte  out  2  constant 0
- wshb_ack  in  1  slave acknowledge
- wshb_dat_sm  in  16  read data
- fifo_wdata  out  16  pixel to FIFO
- fifo_write  out  1  FIFO write strobe
- fifo_wfull  in  1  FIFO full
- frame_done  out  1  single-cycle pulse on the ack of the last pixel of a frame
- active_buf  out  1  framebuffer being fetched

## Operation
- FSM states:
  - WAIT_SYNC (reset state): no bus activity; go to FETCH on frame_sync, or immediately if sync_pending is set.
  - FETCH: issue reads; go to WAIT_SYNC on the ack of pixel HDISP*VDISP-1.
- sync_pending:
  - Set by frame_sync received in FETCH.
  - Cleared when leaving WAIT_SYNC.
  - A frame_sync arriving while the flag is already set is dropped.
- Pixel index pix_idx, width $clog2(HDISP*VDISP):
  - Increments on each ack.
  - Wraps to 0 on the last pixel's ack.
- Address: wshb_adr = base + 2*pix_idx, 32-bit arithmetic.
  - base = BASE_ADDR, or BASE_ADDR + 2*HDISP*VDISP when active_buf=1.
- Output buffer: 2-entry FIFO, count 0..2.
  - Push: wshb_ack.
  - Pop: fifo_write = (count>0) && !fifo_wfull; fifo_wdata = head entry.
  - Push and pop in the same cycle leave count unchanged.
- Bus request:
  - wshb_cyc = wshb_stb.
  - A cycle may start only in FETCH with count<2.
  - Once asserted, stb and adr are held until the cycle that samples ack, regardless of fifo_wfull or frame_sync.
  - stb drops for at least one cycle after each ack (classic single reads).
  - Consequence: the buffer never overflows, and fifo_write is never asserted while fifo_wfull=1.
- Reset mid-operation:
  - All state clears asynchronously and the buffer empties.
  - An outstanding bus cycle is abandoned: stb and cyc fall at once.

## Timing
- Reset values:
  - wshb_cyc = wshb_stb = 0, wshb_adr = BASE_ADDR.
  - fifo_write = 0, fifo_wdata = 0, frame_done = 0, active_buf = 0.
  - State WAIT_SYNC, pix_idx = 0, count = 0, sync_pending = 0.
- stb and adr are registered outputs.
- Latencies:
  - frame_sync to stb: 1 cycle (stb high in the cycle after frame_sync is sampled).
  - ack to fifo_write: 1 cycle minimum.
- Throughput: one word every 2 cycles at best (zero-wait slave).
- frame_done is registered and high in the cycle after the final ack.

## Configuration
- VGA_FETCH_DBLBUF_EN defined:
  - A buf_swap pulse sets swap_pending.
  - On the final ack of a frame, if swap_pending is set, active_buf toggles and swap_pending clears.
  - The next frame reads the other buffer.
- Undefined: buf_swap is ignored and active_buf is tied to 0.

## Test plan
- After reset release with no frame_sync for 100 cycles -> cyc=stb=0, fifo_write=0.
- Zero-wait slave with dat_sm = address[16:1], HDISP=4, VDISP=2, then one frame_sync -> exactly 8 FIFO writes with data 0..7, addresses 0,2,...,14, frame_done once, then idle.
- fifo_wfull held at 1 for 50 cycles mid-frame -> at most 2 acks accepted, then stb stays low; no fifo_write while full; no data lost or reordered after release.
- Second frame_sync arriving mid-frame -> next frame starts with stb on the cycle after the last ack's frame_done; a third sync in the same frame is dropped.
- DBLBUF: buf_swap mid-frame -> current frame finishes at BASE_ADDR; the next frame starts at BASE_ADDR+16 (HDISP=4, VDISP=2); active_buf=1.
- rst asserted while stb=1 and no ack -> stb, cyc and fifo_write go to 0 asynchronously; after release the next fetch starts at BASE_ADDR.

Source files
------------

// File: rtl/vga_fetch.sv
// vga_fetch: Wishbone classic read master that streams the RGB565
// framebuffer into the write side of the display pixel FIFO.
// Walks the frame linearly, stages each acknowledged word in a 2-entry
// buffer and runs at most one frame ahead of the display.
// Optional feature: define VGA_FETCH_DBLBUF_EN to enable framebuffer
// double buffering (buf_swap selects the other buffer at frame end).
module vga_fetch #(
  parameter int          HDISP     = 640,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        frame_sync,
  input  logic        buf_swap,
  output logic [31:0] wshb_adr,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [1:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  input  logic [15:0] wshb_dat_sm,
  output logic [15:0] fifo_wdata,
  output logic        fifo_write,
  input  logic        fifo_wfull,
  output logic        frame_done,
  output logic        active_buf
);

  localparam int              NPIX      = HDISP * VDISP;
  localparam int              IDXW      = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NPIX - 1);
  localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
  localparam logic [31:0]     BUF_BYTES = 32'(2 * NPIX);

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    FETCH     = 1'b1
  } state_t;

  state_t          state_r;
  state_t          next_s;
  logic            sync_pending_r;
  logic [IDXW-1:0] pix_idx_r;
  logic            stb_r;
  logic [31:0]     adr_r;
  logic [15:0]     mem_r [2];
  logic            wr_ptr_r;
  logic            rd_ptr_r;
  logic [1:0]      count_r;
  logic            frame_done_r;
  logic            active_buf_s;

  logic            ack_s;
  logic            last_ack_s;
  logic            pop_s;
  logic            start_s;
  logic [31:0]     base_s;
  logic [31:0]     fetch_adr_s;

  // An ack only counts while our own strobe is up.
  assign ack_s      = stb_r & wshb_ack;
  assign last_ack_s = ack_s & (pix_idx_r == LAST_IDX);
  assign pop_s      = (count_r != 2'd0) & ~fifo_wfull;

  // Next-state logic: leave WAIT_SYNC on a sync (live or remembered), return on the last ack.
  always_comb begin
    next_s = state_r;
    case (state_r)
      WAIT_SYNC: begin
        if (frame_sync || sync_pending_r) begin
          next_s = FETCH;
        end else begin
          next_s = WAIT_SYNC;
        end
      end
      FETCH: begin
        if (last_ack_s) begin
          next_s = WAIT_SYNC;
        end else begin
          next_s = FETCH;
        end
      end
      default: next_s = WAIT_SYNC;
    endcase
  end

  // Start a read when idle on the bus, fetching (or entering fetch) and the buffer has room.
  // Using count_r while stb is low is safe: no push can land in that cycle.
  always_comb begin
    start_s = 1'b0;
    if (!stb_r && (next_s == FETCH) && (count_r < 2'd2)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Framebuffer base follows the selected buffer; pixel address is base + 2*index.
  always_comb begin
    base_s = BASE_ADDR;
    if (active_buf_s) begin
      base_s = BASE_ADDR + BUF_BYTES;
    end else begin
      base_s = BASE_ADDR;
    end
  end

  assign fetch_adr_s = base_s + (32'(pix_idx_r) << 1);

  // FSM state register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r <= WAIT_SYNC;
    end else begin
      state_r <= next_s;
    end
  end

  // Remember one frame_sync seen during a fetch; extra ones are absorbed.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sync_pending_r <= 1'b0;
    end else if ((state_r == WAIT_SYNC) && (next_s == FETCH)) begin
      sync_pending_r <= 1'b0;
    end else if ((state_r == FETCH) && frame_sync) begin
      sync_pending_r <= 1'b1;
    end
  end

  // Pixel index advances on each ack and wraps after the last pixel.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      pix_idx_r <= '0;
    end else if (last_ack_s) begin
      pix_idx_r <= '0;
    end else if (ack_s) begin
      pix_idx_r <= pix_idx_r + IDX_ONE;
    end
  end

  // Registered strobe/address: held until the ack, then dropped for at least one cycle.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      stb_r <= 1'b0;
      adr_r <= BASE_ADDR;
    end else if (start_s) begin
      stb_r <= 1'b1;
      adr_r <= fetch_adr_s;
    end else if (ack_s) begin
      stb_r <= 1'b0;
    end
  end

  // Two-entry output buffer: push on ack, pop whenever the pixel FIFO has room.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mem_r[0] <= 16'h0000;
      mem_r[1] <= 16'h0000;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (ack_s) begin
        mem_r[wr_ptr_r] <= wshb_dat_sm;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({ack_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // End-of-frame pulse in the cycle after the final ack.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= last_ack_s;
    end
  end

`ifdef VGA_FETCH_DBLBUF_EN
  logic active_buf_r;
  logic swap_pending_r;

  // Latch swap requests and apply them only at the frame boundary.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      active_buf_r   <= 1'b0;
      swap_pending_r <= 1'b0;
    end else if (last_ack_s && swap_pending_r) begin
      active_buf_r   <= ~active_buf_r;
      swap_pending_r <= buf_swap;
    end else if (buf_swap) begin
      swap_pending_r <= 1'b1;
    end
  end

  assign active_buf_s = active_buf_r;
`else
  logic unused_buf_swap_s;

  assign unused_buf_swap_s = buf_swap;
  assign active_buf_s      = 1'b0;
`endif

  assign wshb_adr   = adr_r;
  assign wshb_stb   = stb_r;
  assign wshb_cyc   = stb_r;
  assign wshb_we    = 1'b0;
  assign wshb_sel   = 2'b11;
  assign wshb_cti   = 3'b000;
  assign wshb_bte   = 2'b00;
  assign fifo_write = pop_s;
  assign fifo_wdata = mem_r[rd_ptr_r];
  assign frame_done = frame_done_r;
  assign active_buf = active_buf_s;

endmodule

// File: tb/tb_vga_fetch.sv
// tb_vga_fetch: directed self-checking bench for vga_fetch with a 4x2 frame
// and a zero-wait slave returning dat = adr[16:1].
module tb_vga_fetch;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        frame_sync = 1'b0;
  logic        buf_swap = 1'b0;
  logic [31:0] wshb_adr;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [1:0]  wshb_sel, wshb_bte;
  logic [2:0]  wshb_cti;
  logic        wshb_ack;
  logic [15:0] wshb_dat_sm;
  logic [15:0] fifo_wdata;
  logic        fifo_write;
  logic        fifo_wfull = 1'b0;
  logic        frame_done, active_buf;
  logic        ack_en = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;
  int ack_cnt  = 0;
  int fd_cnt   = 0;
  logic [15:0] wr_log[$];

  vga_fetch #(.HDISP(4), .VDISP(2), .BASE_ADDR(32'h0)) dut (
    .CLK(CLK), .rst(rst), .frame_sync(frame_sync), .buf_swap(buf_swap),
    .wshb_adr(wshb_adr), .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb),
    .wshb_we(wshb_we), .wshb_sel(wshb_sel), .wshb_cti(wshb_cti),
    .wshb_bte(wshb_bte), .wshb_ack(wshb_ack), .wshb_dat_sm(wshb_dat_sm),
    .fifo_wdata(fifo_wdata), .fifo_write(fifo_write), .fifo_wfull(fifo_wfull),
    .frame_done(frame_done), .active_buf(active_buf)
  );

  always #5 CLK = ~CLK;

  // Zero-wait slave: acknowledges the strobe in the same cycle.
  assign wshb_ack    = wshb_stb & ack_en;
  assign wshb_dat_sm = wshb_adr[16:1];

  // Monitor: logs FIFO writes, counts acks and frame_done pulses.
  always begin
    @(negedge CLK);
    #2;
    if (!rst) begin
      if (fifo_write) begin
        wr_log.push_back(fifo_wdata);
        if (fifo_wfull) viol++;
      end
      if (wshb_stb && wshb_ack) ack_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name, input int n, input int first_a, input int first_b);
    check({name, "_count"}, wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      if (i < 8) check({name, "_data"}, {16'h0, wr_log[i]}, first_a + i);
      else       check({name, "_data"}, {16'h0, wr_log[i]}, first_b + i - 8);
    end
  endtask

  task automatic wait_fd(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      #1;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_fd_timeout"}, ok, 1'b1);
  endtask

  task automatic wait_writes(input string name, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #3;
      if (wr_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_wr_timeout"}, ok, 1'b1);
  endtask

  task automatic pulse_sync();
    @(negedge CLK);
    frame_sync = 1'b1;
    @(negedge CLK);
    frame_sync = 1'b0;
  endtask

  typedef struct {
    logic        fs;
    logic        exp_stb;
    logic [31:0] exp_adr;
    logic        exp_fw;
    logic [15:0] exp_wd;
    logic        exp_fd;
  } vec_t;

  vec_t vecs[19];
  int   idle_bad;
  int   a0;
  int   stb_seen;
  bit   got;

  initial begin
    // Per-cycle trace of one zero-wait 4x2 frame.
    vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      vecs[2*k+1] = '{1'b0, 1'b1, 32'(2*k), 1'b0, 16'h0, 1'b0};
      vecs[2*k+2] = '{1'b0, 1'b0, 32'h0, 1'b1, 16'(k), (k == 7)};
    end
    vecs[17] = '{1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0};

    // Reset values.
    repeat (3) @(negedge CLK);
    #1;
    check("rst_stb", wshb_stb, 1'b0);
    check("rst_cyc", wshb_cyc, 1'b0);
    check("rst_adr", wshb_adr, 32'h0);
    check("rst_fw", fifo_write, 1'b0);
    check("rst_wd", fifo_wdata, 16'h0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_ab", active_buf, 1'b0);
    check("const_we", wshb_we, 1'b0);
    check("const_sel", wshb_sel, 2'b11);
    check("const_cti", wshb_cti, 3'b000);
    check("const_bte", wshb_bte, 2'b00);
    @(negedge CLK);
    rst = 1'b0;

    // Idle without frame_sync.
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      #1;
      if (wshb_stb || wshb_cyc || fifo_write) idle_bad++;
    end
    check("idle_no_sync", idle_bad, 0);

    // One frame, table-driven.
    wr_log.delete();
    fd_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      frame_sync = vecs[i].fs;
      #1;
      check($sformatf("v%0d_stb", i), wshb_stb, vecs[i].exp_stb);
      check($sformatf("v%0d_cyc", i), wshb_cyc, vecs[i].exp_stb);
      if (vecs[i].exp_stb) check($sformatf("v%0d_adr", i), wshb_adr, vecs[i].exp_adr);
      check($sformatf("v%0d_fw", i), fifo_write, vecs[i].exp_fw);
      if (vecs[i].exp_fw) check($sformatf("v%0d_wd", i), fifo_wdata, vecs[i].exp_wd);
      check($sformatf("v%0d_fd", i), frame_done, vecs[i].exp_fd);
    end
    frame_sync = 1'b0;
    repeat (3) @(negedge CLK);
    check_log("frame1", 8, 0, 0);
    check("frame1_fd_once", fd_cnt, 1);

    // FIFO full for 50 cycles mid-frame.
    wr_log.delete();
    fd_cnt = 0;
    pulse_sync();
    wait_writes("full", 3);
    @(negedge CLK);
    fifo_wfull = 1'b1;
    a0 = ack_cnt;
    repeat (50) @(negedge CLK);
    #1;
    check("full_stb_low", wshb_stb, 1'b0);
    check("full_no_fw", fifo_write, 1'b0);
    #2;
    check("full_acks_le2", (ack_cnt - a0) <= 2, 1'b1);
    @(negedge CLK);
    fifo_wfull = 1'b0;
    wait_fd("full");
    repeat (5) @(negedge CLK);
    check_log("full", 8, 0, 0);
    check("full_fd_once", fd_cnt, 1);

    // Extra syncs mid-frame: one is remembered, the next is dropped.
    wr_log.delete();
    fd_cnt = 0;
    pulse_sync();
    repeat (4) @(negedge CLK);
    pulse_sync();
    repeat (3) @(negedge CLK);
    pulse_sync();
    wait_fd("resync");
    check("resync_stb_at_fd", wshb_stb, 1'b0);
    @(negedge CLK);
    #1;
    check("resync_stb_next", wshb_stb, 1'b1);
    check("resync_adr_next", wshb_adr, 32'h0);
    wait_fd("resync2");
    stb_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #1;
      if (wshb_stb) stb_seen++;
    end
    check("third_sync_dropped", stb_seen, 0);
    check_log("resync", 16, 0, 0);
    check("resync_fd_twice", fd_cnt, 2);

    // Buffer swap requested mid-frame.
    wr_log.delete();
    pulse_sync();
    repeat (4) @(negedge CLK);
    @(negedge CLK);
    buf_swap = 1'b1;
    frame_sync = 1'b1;
    @(negedge CLK);
    buf_swap = 1'b0;
    frame_sync = 1'b0;
    #1;
    check("swap_mid_ab", active_buf, 1'b0);
    wait_fd("swap");
`ifdef VGA_FETCH_DBLBUF_EN
    check("swap_ab_after", active_buf, 1'b1);
    @(negedge CLK);
    #1;
    check("swap_next_stb", wshb_stb, 1'b1);
    check("swap_next_adr", wshb_adr, 32'd16);
    wait_fd("swap2");
    repeat (5) @(negedge CLK);
    check_log("swap", 16, 0, 8);
    check("swap_ab_hold", active_buf, 1'b1);
`else
    check("swap_ab_after", active_buf, 1'b0);
    @(negedge CLK);
    #1;
    check("swap_next_stb", wshb_stb, 1'b1);
    check("swap_next_adr", wshb_adr, 32'd0);
    wait_fd("swap2");
    repeat (5) @(negedge CLK);
    check_log("swap", 16, 0, 0);
`endif

    // Reset while a read is outstanding.
    wr_log.delete();
    pulse_sync();
    wait_writes("rstmid", 3);
    @(negedge CLK);
    ack_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #1;
      if (wshb_stb) begin
        got = 1'b1;
        break;
      end
    end
    check("rstmid_stb_seen", got, 1'b1);
    @(negedge CLK);
    #1;
    check("rstmid_stb_held", wshb_stb, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_stb", wshb_stb, 1'b0);
    check("rstmid_cyc", wshb_cyc, 1'b0);
    check("rstmid_fw", fifo_write, 1'b0);
    check("rstmid_adr", wshb_adr, 32'h0);
    @(negedge CLK);
    rst = 1'b0;
    ack_en = 1'b1;
    wr_log.delete();
    frame_sync = 1'b1;
    @(negedge CLK);
    frame_sync = 1'b0;
    #1;
    check("rstmid_restart_stb", wshb_stb, 1'b1);
    check("rstmid_restart_adr", wshb_adr, 32'h0);
    wait_fd("rstmid");
    repeat (5) @(negedge CLK);
    check_log("rstmid", 8, 0, 0);

    check("no_write_while_full", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
